// File: rtl/sxr_switch_conditioner.sv
// -----------------------------------------------------------------------------
// sxr_switch_conditioner
//
// Conditions raw, asynchronous, bouncing slide-switch levels into clean
// synchronous levels for the sxrRISC621 SW_in bus. Each bit passes through a
// two-flop synchronizer and then a debounce counter. A new level is accepted
// only after DEBOUNCE_CYCLES consecutive synchronized samples disagree with
// the current debounced level.
//
// Optional feature macro: SWCOND_EVENT_LATCH_EN
//   defined   : Event_mask/Event_pending accumulate changes until Event_ack.
//   undefined : Event_mask/Event_pending are tied to 0 and Event_ack is ignored.
//
// Ports
//   Clock          in   system clock, rising edge
//   Resetn         in   synchronous active-low reset
//   SW_raw         in   raw asynchronous switch levels   [WIDTH]
//   SW_out         out  debounced level                  [WIDTH]
//   SW_rise        out  one-cycle debounced 0->1 strobe  [WIDTH]
//   SW_fall        out  one-cycle debounced 1->0 strobe  [WIDTH]
//   SW_changed     out  OR of SW_rise and SW_fall
//   Event_pending  out  some bit changed since last ack
//   Event_mask     out  bits changed since last ack      [WIDTH]
//   Event_ack      in   one-cycle acknowledge of the event latch
// -----------------------------------------------------------------------------
module sxr_switch_conditioner #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] SW_raw,
    output logic [WIDTH-1:0] SW_out,
    output logic [WIDTH-1:0] SW_rise,
    output logic [WIDTH-1:0] SW_fall,
    output logic             SW_changed,
    output logic             Event_pending,
    output logic [WIDTH-1:0] Event_mask,
    input  logic             Event_ack
);

    // Count value on which the level change is committed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    always_comb begin
        out_next  = SW_out;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (s2[i] != SW_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    // Decision cycle: accept the new level, count restarts.
                    out_next[i]  = s2[i];
                    rise_next[i] = s2[i];
                    fall_next[i] = ~s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            s1         <= '0;
            s2         <= '0;
            SW_out     <= '0;
            SW_rise    <= '0;
            SW_fall    <= '0;
            SW_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= SW_raw;
            s2         <= s1;
            SW_out     <= out_next;
            SW_rise    <= rise_next;
            SW_fall    <= fall_next;
            SW_changed <= |(rise_next | fall_next);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

`ifdef SWCOND_EVENT_LATCH_EN
    logic [WIDTH-1:0] mask_next;

    // A change strobed in the same cycle as the ack survives the clear.
    always_comb begin
        mask_next = (Event_ack ? '0 : Event_mask) | (SW_rise | SW_fall);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            Event_mask    <= '0;
            Event_pending <= 1'b0;
        end else begin
            Event_mask    <= mask_next;
            Event_pending <= |mask_next;
        end
    end
`else
    logic unused_event_ack;

    assign unused_event_ack = Event_ack;
    assign Event_mask       = '0;
    assign Event_pending    = 1'b0;
`endif

endmodule
